serial_rx: RTL and testbench



---
 rtl/serial_rx_pkg.sv | 25 ++
 rtl/serial_rx_sync.sv | 21 ++
 rtl/serial_rx.sv | 155 +++++++++++++++
 tb/tb_serial_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Bits needed to hold values 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// Two-stage synchronizer for an asynchronous input; resets to the idle-high level.
module serial_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: start, N LSB-first data bits, even parity, stop.
// Completed words are held in a valid/ready output register with error flags.
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int unsigned N            = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    input  logic         ready,
    output logic [N-1:0] q,
    output logic         valid,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);

    localparam int unsigned CW = clog2(CLKS_PER_BIT);
    localparam int unsigned BW = clog2(N + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

    logic          rx_s;
    logic          rx_prev;
    logic          fall_c;
    logic          sample_c;

    state_t        state, state_next;
    logic [CW-1:0] clk_cnt, clk_cnt_next;
    logic [BW-1:0] bit_cnt, bit_cnt_next;
    logic [N-1:0]  shreg, shreg_next;
    logic          perr_pend, perr_pend_next;
    logic [N-1:0]  q_next;
    logic          valid_next;
    logic          parity_err_next;
    logic          frame_err_next;
    logic          overrun_next;
    logic          busy_next;

    serial_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign fall_c   = rx_prev & ~rx_s;
    // START samples at mid-bit; later states sample once per full bit period.
    assign sample_c = (state == START) ? (clk_cnt == HALF_LAST) : (clk_cnt == FULL_LAST);

    always_comb begin
        state_next      = state;
        clk_cnt_next    = '0;
        bit_cnt_next    = bit_cnt;
        shreg_next      = shreg;
        perr_pend_next  = perr_pend;
        q_next          = q;
        valid_next      = valid & ~ready;
        parity_err_next = parity_err;
        frame_err_next  = frame_err;
        overrun_next    = overrun;

        case (state)
            IDLE: begin
                if (fall_c) begin
                    state_next   = START;
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (sample_c) begin
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (sample_c) begin
                    shreg_next = (shreg >> 1) | (N'(rx_s) << (N - 1));
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt + BW'(1);
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            PARITY: begin
                if (sample_c) begin
                    perr_pend_next = (^shreg) ^ rx_s;
                    state_next     = STOP;
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                if (sample_c) begin
                    // Commit overrides any same-cycle accept of the previous word.
                    q_next          = shreg;
                    parity_err_next = perr_pend;
                    frame_err_next  = ~rx_s;
                    valid_next      = 1'b1;
                    if (valid && !ready) begin
                        overrun_next = 1'b1;
                    end
                    state_next = IDLE;
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_prev    <= 1'b1;
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr_pend  <= 1'b0;
            q          <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_prev    <= rx_s;
            state      <= state_next;
            clk_cnt    <= clk_cnt_next;
            bit_cnt    <= bit_cnt_next;
            shreg      <= shreg_next;
            perr_pend  <= perr_pend_next;
            q          <= q_next;
            valid      <= valid_next;
            parity_err <= parity_err_next;
            frame_err  <= frame_err_next;
            overrun    <= overrun_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx with N=8, CLKS_PER_BIT=4.
module tb_serial_rx;

    localparam int unsigned N   = 8;
    localparam int unsigned CPB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx;
    logic         ready;
    logic [N-1:0] q;
    logic         valid;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_rx #(
        .N            (N),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .ready      (ready),
        .q          (q),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; holds the bit for one bit period.
    task automatic drive_bit(input logic b);
        #1 rx = b;
        repeat (CPB) @(posedge clk);
    endtask

    // Returns on the posedge that begins the stop-sample cycle.
    task automatic send_bits(input logic [7:0] d, input logic p, input logic s);
        @(posedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic expect_commit(input string tag, input logic [7:0] qe, input logic pe,
                                 input logic fe, input logic oe, input logic line);
        #1 rx = line;
        check({tag, "_busy_stop"}, 16'(busy), 16'd1);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 16'(valid), 16'd1);
        check({tag, "_q"}, 16'(q), 16'(qe));
        check({tag, "_perr"}, 16'(parity_err), 16'(pe));
        check({tag, "_ferr"}, 16'(frame_err), 16'(fe));
        check({tag, "_ovr"}, 16'(overrun), 16'(oe));
        check({tag, "_busy_idle"}, 16'(busy), 16'd0);
    endtask

    int busy_cnt;
    int valid_cnt;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", 16'(q), 16'd0);
        check("rst_valid", 16'(valid), 16'd0);
        check("rst_flags", 16'({parity_err, frame_err, overrun}), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // Clean 0xA5, even parity bit 0.
        send_bits(8'hA5, 1'b0, 1'b1);
        expect_commit("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("a5_valid_drop", 16'(valid), 16'd0);
        check("a5_q_hold", 16'(q), 16'hA5);
        repeat (3) @(posedge clk);

        // 0x01 with wrong parity bit.
        send_bits(8'h01, 1'b0, 1'b1);
        expect_commit("p01", 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);

        // 0x3C with low stop bit, line then held low.
        send_bits(8'h3C, 1'b0, 1'b0);
        expect_commit("f3c", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        busy_cnt  = 0;
        valid_cnt = 0;
        for (int i = 0; i < 3 * CPB + 4; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (valid) valid_cnt++;
        end
        check("f3c_no_retrig_busy", 16'(busy_cnt), 16'd0);
        check("f3c_no_second_commit", 16'(valid_cnt), 16'd0);
        rx = 1'b1;
        repeat (6) @(posedge clk);

        // One-cycle low glitch on rx.
        #1 rx = 1'b0;
        @(posedge clk);
        #1 rx = 1'b1;
        busy_cnt  = 0;
        valid_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (valid) valid_cnt++;
        end
        check("glitch_busy_cycles", 16'(busy_cnt), 16'd2);
        check("glitch_no_valid", 16'(valid_cnt), 16'd0);
        check("glitch_q_hold", 16'(q), 16'h3C);

        // Reset during data bit 4 of a 0x5A frame.
        @(posedge clk);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 16'(busy), 16'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_q", 16'(q), 16'd0);
        check("mid_rst_flags", 16'({valid, parity_err, frame_err, overrun}), 16'd0);
        check("mid_rst_busy", 16'(busy), 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        send_bits(8'h5A, 1'b0, 1'b1);
        expect_commit("r5a", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("r5a_valid_drop", 16'(valid), 16'd0);
        ready = 1'b0;
        repeat (3) @(posedge clk);

        // Backpressure: two back-to-back frames with ready low.
        send_bits(8'h11, 1'b0, 1'b1);
        expect_commit("bp11", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(8'h22, 1'b0, 1'b1);
        expect_commit("bp22", 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check("bp_accept_valid", 16'(valid), 16'd0);
        check("bp_overrun_sticky", 16'(overrun), 16'd1);
        check("bp_q_hold", 16'(q), 16'h22);
        repeat (3) @(posedge clk);
        #1;
        check("bp_overrun_later", 16'(overrun), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
